trace_cmd_scheduler: RTL and testbench
======================================

# trace_cmd_scheduler

Sequences decoded trace commands (code + address) onto the L2 simulator's two command paths: the L1-side request port (data read/write, instruction fetch) and the shared-bus snoop port (invalidate, read, write, RWITM). Maintenance commands (clear, print) are issued as blocking requests to the cache and held until the cache acknowledges them. One command is in flight at a time, with valid/ready handshakes on every port. Sits between the trace reader and the L2 cache model; optional per-class statistics counters.

## Interface
- addressSize, 32, width of trace and bus addresses
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  trace command present
- cmd_ready  output  1  scheduler accepts command this cycle
- cmd_code  input  4  trace command code 0–15
- cmd_addr  input  addressSize  trace address
- l1_valid  output  1  L1 request valid
- l1_ready  input  1  cache accepts L1 request
- l1_op  output  16  ASCII op: "DR", "DW", "IR"
- l1_addr  output  addressSize  L1 request address
- snoop_valid  output  1  snoop request valid
- snoop_ready  input  1  cache accepts snoop
- snoop_op  output  8  ASCII op: "I", "R", "W", "M"
- snoop_addr  output  addressSize  snoop address
- clear_req  output  1  clear cache and reset states (code 8)
- print_req  output  1  print valid lines (code 9)
- maint_done  input  1  cache finished the active clear/print
- busy  output  1  high in every state except IDLE
- err_count  output  16  illegal codes dropped, saturating
- rd_count, wr_count, if_count, snoop_count  output  32 each  present only with TRACE_SCHED_STATS_EN

## Operation
- FSM states: IDLE, L1_ISSUE, SNOOP_ISSUE, MAINT_WAIT.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, decode cmd_code:
  - 0/1/2: load l1_addr and l1_op ("DR"/"DW"/"IR"), go to L1_ISSUE.
  - 3/4/5/6: load snoop_addr and snoop_op ("I"/"R"/"W"/"M"), go to SNOOP_ISSUE.
  - 8: go to MAINT_WAIT with clear_req. 9: go to MAINT_WAIT with print_req.
  - 7 and 10–15: illegal. Increment err_count (saturates at 0xFFFF) and stay in IDLE. Nothing is issued.
- L1_ISSUE: l1_valid=1, l1_op and l1_addr held stable. When l1_ready=1, go to IDLE.
- SNOOP_ISSUE: same rules, using snoop_valid and snoop_ready.
- MAINT_WAIT: clear_req or print_req held high until maint_done=1 is sampled, then go to IDLE. cmd_addr is ignored for maintenance commands.
- maint_done, l1_ready and snoop_ready are ignored outside their own state.
- Op and address registers keep their last issued value after the handshake.
- At most one of l1_valid, snoop_valid, clear_req, print_req is high at any time.

## Timing
- Reset values: state IDLE. cmd_ready=0 while reset is high and 1 in the first cycle after. All valids and reqs 0, ops 0, addrs 0, busy 0, err_count 0, stats 0.
- The command is accepted at edge N. Request valid (or req) is high from cycle N+1.
- The cache handshake at edge M returns the FSM to IDLE. cmd_ready is high in cycle M+1.
- Minimum throughput is one legal command per 2 cycles. An illegal code is absorbed in 1 cycle, with cmd_ready staying high.
- maint_done high in the same cycle that clear_req first rises completes the maintenance command, giving a 1-cycle request.
- Reset mid-operation: the in-flight command is dropped without completion, all outputs return to reset values at the next edge, and no counter is incremented.

## Configuration
- TRACE_SCHED_STATS_EN defined:
  - rd_count (code 0), wr_count (code 1), if_count (code 2) and snoop_count (codes 3–6) are present.
  - Each counter increments on its request handshake, not on acceptance, and wraps at 2^32.
  - A completed clear (code 8, maint_done) zeroes all four counters at the same edge.
- TRACE_SCHED_STATS_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset, then code 0 addr 0x0000_1234 with l1_ready low for 3 cycles → l1_valid high 4 cycles, l1_op="DR", l1_addr=0x1234 stable, cmd_ready low throughout, back in IDLE the cycle after the handshake.
- Back-to-back codes 1, 2, 4, 6 with ready tied high → ops "DW", "IR", "R", "M" in order, each valid for exactly 1 cycle, one command per 2 cycles.
- Codes 7, 15, 10 → err_count=3, no valid/req asserted, cmd_ready stays high. Then 0x10000 illegal codes → err_count=0xFFFF.
- Code 9 with maint_done delayed 5 cycles → print_req high 6 cycles, busy high, no other port driven.
- Reset asserted during SNOOP_ISSUE with snoop_ready low → snoop_valid=0 and cmd_ready=1 after reset releases. The next command issues normally.
- With TRACE_SCHED_STATS_EN defined: issue 3×code 0, 2×code 5, then code 8 → rd_count=3 and snoop_count=2 before the clear, all counters 0 after maint_done.

Source files
------------

// File: rtl/trace_cmd_scheduler.sv
// trace_cmd_scheduler: issues decoded trace commands one at a time onto the
// L1 request port, the snoop port, or the clear/print maintenance requests.
// Optional per-class statistics counters are built when the macro
// TRACE_SCHED_STATS_EN is defined.
module trace_cmd_scheduler #(
    parameter int unsigned addressSize = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_code,
    input  logic [addressSize-1:0] cmd_addr,
    output logic                   l1_valid,
    input  logic                   l1_ready,
    output logic [15:0]            l1_op,
    output logic [addressSize-1:0] l1_addr,
    output logic                   snoop_valid,
    input  logic                   snoop_ready,
    output logic [7:0]             snoop_op,
    output logic [addressSize-1:0] snoop_addr,
    output logic                   clear_req,
    output logic                   print_req,
    input  logic                   maint_done,
    output logic                   busy,
    output logic [15:0]            err_count
`ifdef TRACE_SCHED_STATS_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count,
    output logic [31:0]            if_count,
    output logic [31:0]            snoop_count
`endif
);

    // ASCII op encodings
    localparam logic [15:0] OpDr = 16'h4452;  // "DR"
    localparam logic [15:0] OpDw = 16'h4457;  // "DW"
    localparam logic [15:0] OpIr = 16'h4952;  // "IR"
    localparam logic [7:0]  OpI  = 8'h49;     // "I"
    localparam logic [7:0]  OpR  = 8'h52;     // "R"
    localparam logic [7:0]  OpW  = 8'h57;     // "W"
    localparam logic [7:0]  OpM  = 8'h4D;     // "M"

    typedef enum logic [1:0] {
        StIdle,
        StL1Issue,
        StSnoopIssue,
        StMaintWait
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            l1_op_q, l1_op_d;
    logic [addressSize-1:0] l1_addr_q, l1_addr_d;
    logic [7:0]             snoop_op_q, snoop_op_d;
    logic [addressSize-1:0] snoop_addr_q, snoop_addr_d;
    logic                   maint_clr_q, maint_clr_d;  // 1: clear, 0: print
    logic [15:0]            err_count_q, err_count_d;
`ifdef TRACE_SCHED_STATS_EN
    logic [31:0]            rd_count_q, rd_count_d;
    logic [31:0]            wr_count_q, wr_count_d;
    logic [31:0]            if_count_q, if_count_d;
    logic [31:0]            snoop_count_q, snoop_count_d;
`endif

    logic accept;

    // Handshake and port outputs decoded directly from the state register
    always_comb begin
        cmd_ready   = (state_q == StIdle) && !reset;
        accept      = cmd_valid && cmd_ready;
        l1_valid    = (state_q == StL1Issue);
        snoop_valid = (state_q == StSnoopIssue);
        clear_req   = (state_q == StMaintWait) && maint_clr_q;
        print_req   = (state_q == StMaintWait) && !maint_clr_q;
        busy        = (state_q != StIdle);
        l1_op       = l1_op_q;
        l1_addr     = l1_addr_q;
        snoop_op    = snoop_op_q;
        snoop_addr  = snoop_addr_q;
        err_count   = err_count_q;
`ifdef TRACE_SCHED_STATS_EN
        rd_count    = rd_count_q;
        wr_count    = wr_count_q;
        if_count    = if_count_q;
        snoop_count = snoop_count_q;
`endif
    end

    // Next-state: decode in IDLE, wait for the owning handshake elsewhere
    always_comb begin
        state_d      = state_q;
        l1_op_d      = l1_op_q;
        l1_addr_d    = l1_addr_q;
        snoop_op_d   = snoop_op_q;
        snoop_addr_d = snoop_addr_q;
        maint_clr_d  = maint_clr_q;
        err_count_d  = err_count_q;
`ifdef TRACE_SCHED_STATS_EN
        rd_count_d    = rd_count_q;
        wr_count_d    = wr_count_q;
        if_count_d    = if_count_q;
        snoop_count_d = snoop_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (cmd_code)
                        4'd0, 4'd1, 4'd2: begin
                            l1_addr_d = cmd_addr;
                            l1_op_d   = (cmd_code == 4'd0) ? OpDr :
                                        (cmd_code == 4'd1) ? OpDw : OpIr;
                            state_d   = StL1Issue;
                        end
                        4'd3, 4'd4, 4'd5, 4'd6: begin
                            snoop_addr_d = cmd_addr;
                            snoop_op_d   = (cmd_code == 4'd3) ? OpI :
                                           (cmd_code == 4'd4) ? OpR :
                                           (cmd_code == 4'd5) ? OpW : OpM;
                            state_d      = StSnoopIssue;
                        end
                        4'd8: begin
                            maint_clr_d = 1'b1;
                            state_d     = StMaintWait;
                        end
                        4'd9: begin
                            maint_clr_d = 1'b0;
                            state_d     = StMaintWait;
                        end
                        default: begin
                            // Illegal code: absorbed in place, counter saturates
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                        end
                    endcase
                end
            end
            StL1Issue: begin
                if (l1_ready) begin
                    state_d = StIdle;
`ifdef TRACE_SCHED_STATS_EN
                    if (l1_op_q == OpDr) begin
                        rd_count_d = rd_count_q + 32'd1;
                    end else if (l1_op_q == OpDw) begin
                        wr_count_d = wr_count_q + 32'd1;
                    end else begin
                        if_count_d = if_count_q + 32'd1;
                    end
`endif
                end
            end
            StSnoopIssue: begin
                if (snoop_ready) begin
                    state_d = StIdle;
`ifdef TRACE_SCHED_STATS_EN
                    snoop_count_d = snoop_count_q + 32'd1;
`endif
                end
            end
            StMaintWait: begin
                if (maint_done) begin
                    state_d = StIdle;
`ifdef TRACE_SCHED_STATS_EN
                    if (maint_clr_q) begin
                        rd_count_d    = '0;
                        wr_count_d    = '0;
                        if_count_d    = '0;
                        snoop_count_d = '0;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            l1_op_q       <= '0;
            l1_addr_q     <= '0;
            snoop_op_q    <= '0;
            snoop_addr_q  <= '0;
            maint_clr_q   <= 1'b0;
            err_count_q   <= '0;
`ifdef TRACE_SCHED_STATS_EN
            rd_count_q    <= '0;
            wr_count_q    <= '0;
            if_count_q    <= '0;
            snoop_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            l1_op_q       <= l1_op_d;
            l1_addr_q     <= l1_addr_d;
            snoop_op_q    <= snoop_op_d;
            snoop_addr_q  <= snoop_addr_d;
            maint_clr_q   <= maint_clr_d;
            err_count_q   <= err_count_d;
`ifdef TRACE_SCHED_STATS_EN
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
            if_count_q    <= if_count_d;
            snoop_count_q <= snoop_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_trace_cmd_scheduler.sv
// Bench for trace_cmd_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_trace_cmd_scheduler;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_code;
    logic [31:0] cmd_addr;
    logic        l1_valid;
    logic        l1_ready;
    logic [15:0] l1_op;
    logic [31:0] l1_addr;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [7:0]  snoop_op;
    logic [31:0] snoop_addr;
    logic        clear_req;
    logic        print_req;
    logic        maint_done;
    logic        busy;
    logic [15:0] err_count;
`ifdef TRACE_SCHED_STATS_EN
    logic [31:0] rd_count, wr_count, if_count, snoop_count;
`endif

    trace_cmd_scheduler #(.addressSize(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_addr   (cmd_addr),
        .l1_valid   (l1_valid),
        .l1_ready   (l1_ready),
        .l1_op      (l1_op),
        .l1_addr    (l1_addr),
        .snoop_valid(snoop_valid),
        .snoop_ready(snoop_ready),
        .snoop_op   (snoop_op),
        .snoop_addr (snoop_addr),
        .clear_req  (clear_req),
        .print_req  (print_req),
        .maint_done (maint_done),
        .busy       (busy),
        .err_count  (err_count)
`ifdef TRACE_SCHED_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .if_count   (if_count),
        .snoop_count(snoop_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: the single pending command, if any
    // pend: 0 none, 1 L1 request, 2 snoop request, 3 clear, 4 print
    int          pend = 0;
    int          m_l1code = 0;
    logic [15:0] m_l1op = '0;
    logic [31:0] m_l1addr = '0;
    logic [7:0]  m_snop = '0;
    logic [31:0] m_snaddr = '0;
    int          m_err = 0;
    logic [31:0] m_rd = '0, m_wr = '0, m_if = '0, m_sn = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            pend <= 0; m_l1op <= '0; m_l1addr <= '0; m_snop <= '0; m_snaddr <= '0;
            m_err <= 0; m_rd <= '0; m_wr <= '0; m_if <= '0; m_sn <= '0;
        end else begin
            case (pend)
                0: if (cmd_valid) begin
                    case (cmd_code)
                        4'd0: begin pend <= 1; m_l1code <= 0; m_l1op <= "DR"; m_l1addr <= cmd_addr; end
                        4'd1: begin pend <= 1; m_l1code <= 1; m_l1op <= "DW"; m_l1addr <= cmd_addr; end
                        4'd2: begin pend <= 1; m_l1code <= 2; m_l1op <= "IR"; m_l1addr <= cmd_addr; end
                        4'd3: begin pend <= 2; m_snop <= "I"; m_snaddr <= cmd_addr; end
                        4'd4: begin pend <= 2; m_snop <= "R"; m_snaddr <= cmd_addr; end
                        4'd5: begin pend <= 2; m_snop <= "W"; m_snaddr <= cmd_addr; end
                        4'd6: begin pend <= 2; m_snop <= "M"; m_snaddr <= cmd_addr; end
                        4'd8: pend <= 3;
                        4'd9: pend <= 4;
                        default: if (m_err < 65535) m_err <= m_err + 1;
                    endcase
                end
                1: if (l1_ready) begin
                    pend <= 0;
                    if (m_l1code == 0) m_rd <= m_rd + 1;
                    else if (m_l1code == 1) m_wr <= m_wr + 1;
                    else m_if <= m_if + 1;
                end
                2: if (snoop_ready) begin
                    pend <= 0;
                    m_sn <= m_sn + 1;
                end
                3: if (maint_done) begin
                    pend <= 0;
                    m_rd <= '0; m_wr <= '0; m_if <= '0; m_sn <= '0;
                end
                default: if (maint_done) pend <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, (pend == 0) && !reset);
            chk("busy", busy, pend != 0);
            chk("l1_valid", l1_valid, pend == 1);
            chk("snoop_valid", snoop_valid, pend == 2);
            chk("clear_req", clear_req, pend == 3);
            chk("print_req", print_req, pend == 4);
            chk("l1_op", l1_op, m_l1op);
            chk("l1_addr", l1_addr, m_l1addr);
            chk("snoop_op", snoop_op, m_snop);
            chk("snoop_addr", snoop_addr, m_snaddr);
            chk("err_count", err_count, m_err);
`ifdef TRACE_SCHED_STATS_EN
            chk("rd_count", rd_count, m_rd);
            chk("wr_count", wr_count, m_wr);
            chk("if_count", if_count, m_if);
            chk("snoop_count", snoop_count, m_sn);
`endif
        end
    end

    // Present a command and hold it until it is accepted (bounded)
    task automatic send(input logic [3:0] c, input logic [31:0] a);
        logic r;
        logic done;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_code  = c;
        cmd_addr  = a;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        if (!done) chk("send_timeout", 1, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] ill [7];
        int c0;
        ill[0] = 4'd7;  ill[1] = 4'd10; ill[2] = 4'd11; ill[3] = 4'd12;
        ill[4] = 4'd13; ill[5] = 4'd14; ill[6] = 4'd15;
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_addr = '0;
        l1_ready = 1'b0; snoop_ready = 1'b0; maint_done = 1'b0;
        step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready_low", cmd_ready, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_err", err_count, 0);
        step();

        // L1 read held off by l1_ready for 3 cycles
        send(4'd0, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dr_valid_wait", l1_valid, 1);
            chk("dr_ready_low", cmd_ready, 0);
            chk("dr_addr", l1_addr, 32'h1234);
            step();
        end
        l1_ready = 1'b1;
        @(negedge clk);
        chk("dr_valid_4th", l1_valid, 1);
        chk("dr_op", l1_op, 16'h4452);
        step();
        l1_ready = 1'b0;
        @(negedge clk);
        chk("dr_valid_after", l1_valid, 0);
        chk("dr_idle_ready", cmd_ready, 1);
        chk("dr_op_kept", l1_op, 16'h4452);
        step();

        // Back-to-back with ready tied high
        l1_ready = 1'b1; snoop_ready = 1'b1;
        c0 = cyc;
        send(4'd1, 32'hA0);
        @(negedge clk); chk("b2b_dw", l1_op, 16'h4457);
        send(4'd2, 32'hA1);
        @(negedge clk); chk("b2b_ir", l1_op, 16'h4952);
        send(4'd4, 32'hA2);
        @(negedge clk); chk("b2b_r", snoop_op, 8'h52);
        send(4'd6, 32'hA3);
        @(negedge clk); chk("b2b_m", snoop_op, 8'h4D);
        chk("b2b_cycles", cyc - c0, 7);
        step();
        l1_ready = 1'b0; snoop_ready = 1'b0;

        // Illegal codes and saturation
        do_reset();
        send(4'd7, 32'h1); send(4'd15, 32'h2); send(4'd10, 32'h3);
        @(negedge clk);
        chk("err_three", err_count, 3);
        chk("err_no_busy", busy, 0);
        step();
        cmd_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            cmd_code = ill[$urandom_range(0, 6)];
            cmd_addr = $urandom;
            step();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("err_saturated", err_count, 16'hFFFF);
        step();

        // Print with maint_done delayed 5 cycles
        send(4'd9, 32'hDEAD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("print_req_wait", print_req, 1);
            chk("print_busy", busy, 1);
            chk("print_no_clear", clear_req, 0);
            step();
        end
        maint_done = 1'b1;
        @(negedge clk);
        chk("print_req_6th", print_req, 1);
        step();
        maint_done = 1'b0;
        @(negedge clk);
        chk("print_req_done", print_req, 0);
        step();

        // Clear completing in its first cycle
        maint_done = 1'b1;
        send(4'd8, 32'h0);
        @(negedge clk);
        chk("clear_one_cycle", clear_req, 1);
        step();
        @(negedge clk);
        chk("clear_dropped", clear_req, 0);
        maint_done = 1'b0;
        step();

        // Reset during SNOOP_ISSUE
        send(4'd3, 32'h0000_ABCD);
        @(negedge clk);
        chk("snoop_pending", snoop_valid, 1);
        step();
        do_reset();
        @(negedge clk);
        chk("rst_snoop_valid", snoop_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_snoop_addr", snoop_addr, 0);
        snoop_ready = 1'b1;
        send(4'd5, 32'h5555);
        @(negedge clk);
        chk("after_rst_op", snoop_op, 8'h57);
        chk("after_rst_addr", snoop_addr, 32'h5555);
        step();
        snoop_ready = 1'b0;

`ifdef TRACE_SCHED_STATS_EN
        do_reset();
        l1_ready = 1'b1; snoop_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(4'd0, $urandom);
        for (int i = 0; i < 2; i++) send(4'd5, $urandom);
        step();
        @(negedge clk);
        chk("stats_rd3", rd_count, 3);
        chk("stats_sn2", snoop_count, 2);
        send(4'd8, 32'h0);
        @(negedge clk);
        chk("stats_hold", rd_count, 3);
        maint_done = 1'b1;
        step();
        maint_done = 1'b0;
        @(negedge clk);
        chk("stats_rd_clr", rd_count, 0);
        chk("stats_sn_clr", snoop_count, 0);
        step();
        l1_ready = 1'b0; snoop_ready = 1'b0;
`endif

        // Randomized traffic, checked by the every-cycle compare
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cmd_valid   = ($urandom_range(0, 2) != 0);
            cmd_code    = 4'($urandom);
            cmd_addr    = $urandom;
            l1_ready    = $urandom_range(0, 1) != 0;
            snoop_ready = $urandom_range(0, 1) != 0;
            maint_done  = $urandom_range(0, 2) == 0;
            reset       = $urandom_range(0, 149) == 0;
            step();
        end
        reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
